// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver core.
// Edge-detects rxDone/rxErr, queues received bytes in a circular FIFO with
// first-word fall-through output, tracks a sticky overflow flag and a
// saturating error counter. A synchronous clear flushes everything.
module uart_rx_fifo #(
  parameter int Depth         = 8,
  parameter int ErrCountWidth = 8
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [7:0]               rxData,
  input  logic                     rxDone,
  input  logic                     rxErr,
  input  logic                     clear,
  output logic [7:0]               outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(Depth):0]   count,
  output logic                     overflow,
  output logic [ErrCountWidth-1:0] errCount
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  logic                     done_q, err_q;
  logic                     pend_q, pend_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic [ErrCountWidth-1:0] ecnt_q, ecnt_d;
  logic [7:0]               mem [Depth];

  logic push_ev, err_ev, full, pop, wr_en;

  // Rising-edge events; a held-high input produces a single event.
  assign push_ev = rxDone & ~done_q;
  assign err_ev  = rxErr & ~err_q;

  assign full  = (cnt_q == CW'(Depth));
  assign pop   = outValid & outReady;
  // A pending byte is written unless clear wins or the FIFO is full with no
  // pop freeing a slot in the same cycle.
  assign wr_en = pend_q & ~clear & (~full | pop);

  assign outValid = (cnt_q != '0);
  assign outData  = outValid ? mem[rd_ptr_q] : 8'h00;
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign errCount = ecnt_q;

  // Next-state for pointers, occupancy, flags; clear overrides everything.
  always_comb begin
    pend_d   = push_ev & ~clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ecnt_d   = ecnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      ecnt_d   = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (pend_q && full && !pop) ovf_d = 1'b1;
      if (err_ev && (ecnt_q != '1)) ecnt_d = ecnt_q + ErrCountWidth'(1);
    end
  end

  // Control state register; edge history keeps updating through clear.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      done_q   <= rxDone;
      err_q    <= rxErr;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ecnt_q   <= ecnt_d;
    end
  end

  // Storage array; contents only matter where count says they are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= rxData;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand sequences for the
// multi-cycle corners, and random stimulus against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] rxData;
  logic       rxDone, rxErr, clear, outReady;
  logic [7:0] outData;
  logic       outValid, overflow;
  logic [3:0] count;
  logic [7:0] errCount;

  uart_rx_fifo #(.Depth(DEPTH), .ErrCountWidth(8)) dut (
    .clk(clk), .nReset(nReset), .rxData(rxData), .rxDone(rxDone),
    .rxErr(rxErr), .clear(clear), .outData(outData), .outValid(outValid),
    .outReady(outReady), .count(count), .overflow(overflow),
    .errCount(errCount)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: byte queue plus flags, updated per clock from the rules.
  logic [7:0] mq[$];
  bit m_ovf, m_prevD, m_prevE, m_pend;
  int m_ec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".count"}, 32'(count), 32'(mq.size()));
    chk({nm, ".valid"}, 32'(outValid), 32'(mq.size() > 0));
    chk({nm, ".data"}, 32'(outData), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    chk({nm, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({nm, ".err"}, 32'(errCount), 32'(m_ec));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_prevD = 0; m_prevE = 0; m_pend = 0; m_ec = 0;
  endtask

  // One clock: capture inputs, advance DUT, advance model, compare.
  task automatic tick(input string nm = "tick");
    bit pop, pe, ee, clr;
    int sz0;
    logic [7:0] d;
    pop = (mq.size() > 0) && outReady;
    sz0 = mq.size();
    pe  = rxDone && !m_prevD;
    ee  = rxErr && !m_prevE;
    clr = clear;
    d   = rxData;
    m_prevD = rxDone;
    m_prevE = rxErr;
    @(posedge clk); #1;
    if (clr) begin
      mq.delete(); m_ovf = 0; m_ec = 0; m_pend = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        if (sz0 == DEPTH && !pop) m_ovf = 1;
        else mq.push_back(d);
      end
      if (ee && m_ec < 255) m_ec++;
      m_pend = pe;
    end
    chk_model(nm);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rxDone = 1'b1; tick("push");
    rxDone = 1'b0; rxData = b; tick("push");
  endtask

  task automatic err_pulse();
    rxErr = 1'b1; tick("err");
    rxErr = 1'b0; tick("err");
  endtask

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [3:0] ec;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{done:1'b1, data:8'h00, rdy:1'b0, ev:1'b0, ed:8'h00, ec:4'd0};
    vt[1]  = '{done:1'b0, data:8'hA5, rdy:1'b0, ev:1'b1, ed:8'hA5, ec:4'd1};
    vt[2]  = '{done:1'b0, data:8'h00, rdy:1'b0, ev:1'b1, ed:8'hA5, ec:4'd1};
    vt[3]  = '{done:1'b0, data:8'h00, rdy:1'b1, ev:1'b0, ed:8'h00, ec:4'd0};
    vt[4]  = '{done:1'b1, data:8'h11, rdy:1'b0, ev:1'b0, ed:8'h00, ec:4'd0};
    vt[5]  = '{done:1'b1, data:8'h3C, rdy:1'b0, ev:1'b1, ed:8'h3C, ec:4'd1};
    vt[6]  = '{done:1'b1, data:8'h44, rdy:1'b0, ev:1'b1, ed:8'h3C, ec:4'd1};
    vt[7]  = '{done:1'b0, data:8'h55, rdy:1'b0, ev:1'b1, ed:8'h3C, ec:4'd1};
    vt[8]  = '{done:1'b1, data:8'h00, rdy:1'b0, ev:1'b1, ed:8'h3C, ec:4'd1};
    vt[9]  = '{done:1'b0, data:8'h77, rdy:1'b0, ev:1'b1, ed:8'h3C, ec:4'd2};
    vt[10] = '{done:1'b0, data:8'h00, rdy:1'b1, ev:1'b1, ed:8'h77, ec:4'd1};
    vt[11] = '{done:1'b0, data:8'h00, rdy:1'b1, ev:1'b0, ed:8'h00, ec:4'd0};

    nReset = 1'b0; rxData = 8'h00; rxDone = 1'b0; rxErr = 1'b0;
    clear = 1'b0; outReady = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    chk("reset.count", 32'(count), 0);
    chk("reset.valid", 32'(outValid), 0);
    chk("reset.data", 32'(outData), 0);
    chk("reset.ovf", 32'(overflow), 0);
    chk("reset.err", 32'(errCount), 0);

    // Directed table: single byte latency, FWFT pop, held rxDone.
    for (int i = 0; i < 12; i++) begin
      rxDone = vt[i].done; rxData = vt[i].data; outReady = vt[i].rdy;
      tick("vec");
      chk($sformatf("vec%0d.valid", i), 32'(outValid), 32'(vt[i].ev));
      chk($sformatf("vec%0d.data", i), 32'(outData), 32'(vt[i].ed));
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].ec));
    end
    outReady = 1'b0;

    // Fill past full: 9 bytes, last one dropped, overflow sticks.
    for (int i = 0; i < 9; i++) push_byte(8'(i));
    chk("fill.count", 32'(count), 8);
    chk("fill.ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain.data", 32'(outData), 32'(i));
      outReady = 1'b1; tick("drain");
    end
    outReady = 1'b0; tick("drain");
    chk("drain.count", 32'(count), 0);
    chk("drain.ovf", 32'(overflow), 1);
    clear = 1'b1; tick("clr"); clear = 1'b0;
    chk("clr.ovf", 32'(overflow), 0);

    // Full with simultaneous push and pop: no overflow, FF comes out last.
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    chk("full.count", 32'(count), 8);
    rxDone = 1'b1; tick("fpp");
    rxDone = 1'b0; rxData = 8'hFF; outReady = 1'b1; tick("fpp");
    outReady = 1'b0;
    chk("fpp.count", 32'(count), 8);
    chk("fpp.ovf", 32'(overflow), 0);
    chk("fpp.head", 32'(outData), 32'h11);
    for (int i = 0; i < 8; i++) begin
      chk("fpp.drain", 32'(outData), (i == 7) ? 32'hFF : 32'(8'h11 + 8'(i)));
      outReady = 1'b1; tick("fpp");
    end
    outReady = 1'b0;
    chk("fpp.empty", 32'(outValid), 0);

    // rxDone held 5 cycles yields one byte.
    rxDone = 1'b1; rxData = 8'h5A;
    repeat (5) tick("held");
    rxDone = 1'b0; tick("held");
    chk("held.count", 32'(count), 1);
    chk("held.data", 32'(outData), 32'h5A);

    // 300 error pulses saturate at 255; FIFO untouched.
    for (int i = 0; i < 300; i++) err_pulse();
    chk("err.sat", 32'(errCount), 255);
    chk("err.count", 32'(count), 1);
    chk("err.data", 32'(outData), 32'h5A);

    // Clear with 3 queued, overflow set, errCount 4, and a push event.
    clear = 1'b1; tick("clr"); clear = 1'b0;
    for (int i = 0; i < 9; i++) push_byte(8'h20 + 8'(i));
    outReady = 1'b1; repeat (5) tick("pre"); outReady = 1'b0;
    for (int i = 0; i < 4; i++) err_pulse();
    chk("pre.count", 32'(count), 3);
    chk("pre.ovf", 32'(overflow), 1);
    chk("pre.err", 32'(errCount), 4);
    rxDone = 1'b1; clear = 1'b1; tick("clrpush");
    clear = 1'b0; rxDone = 1'b0; rxData = 8'h99;
    chk("clrpush.count", 32'(count), 0);
    chk("clrpush.valid", 32'(outValid), 0);
    chk("clrpush.ovf", 32'(overflow), 0);
    chk("clrpush.err", 32'(errCount), 0);
    tick("clrpush");
    chk("clrpush.discard", 32'(count), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rxDone   = ($urandom_range(0, 2) == 0);
      rxErr    = ($urandom_range(0, 3) == 0);
      clear    = ($urandom_range(0, 60) == 0);
      outReady = ($urandom_range(0, 2) == 0);
      rxData   = 8'($urandom);
      tick("rand");
    end
    rxDone = 1'b0; rxErr = 1'b0; clear = 1'b0; outReady = 1'b0;
    tick("idle"); tick("idle");

    // Async reset mid-stream with count=5.
    clear = 1'b1; tick("clr"); clear = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    err_pulse();
    chk("arst.pre", 32'(count), 5);
    #2 nReset = 1'b0;
    #1;
    model_reset();
    chk("arst.count", 32'(count), 0);
    chk("arst.valid", 32'(outValid), 0);
    chk("arst.data", 32'(outData), 0);
    chk("arst.ovf", 32'(overflow), 0);
    chk("arst.err", 32'(errCount), 0);
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
    push_byte(8'hC3); tick("post");
    chk("post.data", 32'(outData), 32'hC3);
    chk("post.count", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
